// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the register write-back path
// Contents: icode constants, register IDs, stat encodings, write-back FSM state type.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;
  typedef enum logic {RUN, HALTED} wb_state_t;
endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode: combinational destination-register decode for write-back
// Ports: icode/ra/rb/cnd in; dst_e (valE target), dst_m (valM target) out, REG_NONE = no write.
module wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);
  always_comb begin
    dst_e = (icode == I_RRMOVQ) ? (cnd ? rb : REG_NONE) :
            (icode inside {I_IRMOVQ, I_OPQ}) ? rb :
            (icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? REG_RSP : REG_NONE;
    dst_m = (icode inside {I_MRMOVQ, I_POPQ}) ? ra : REG_NONE;
  end
endmodule

// File: rtl/writeback_regfile_seq.sv
// writeback_regfile_seq: Y86-64 write-back stage owning the 15x64 architectural register file
// Ports: clk, rst_n (sync, active-low); wb_valid/icode/rA/rB/cnd/valE/valM/stat commit inputs;
// reg_file0..14 registered contents; halted sticky status; dstE_o/dstM_o decoded destinations.
// Optional WB_RETIRE_CNT_EN adds retired_cnt, a 64-bit count of committed AOK instructions.
module writeback_regfile_seq
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
  parameter int          NREG     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [1:0]  stat,
  output logic [63:0] reg_file0,
  output logic [63:0] reg_file1,
  output logic [63:0] reg_file2,
  output logic [63:0] reg_file3,
  output logic [63:0] reg_file4,
  output logic [63:0] reg_file5,
  output logic [63:0] reg_file6,
  output logic [63:0] reg_file7,
  output logic [63:0] reg_file8,
  output logic [63:0] reg_file9,
  output logic [63:0] reg_file10,
  output logic [63:0] reg_file11,
  output logic [63:0] reg_file12,
  output logic [63:0] reg_file13,
  output logic [63:0] reg_file14,
  output logic        halted,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retired_cnt
`endif
);
  logic [63:0] regs [NREG];
  logic [3:0]  dst_e, dst_m;
  logic        commit;
  wb_state_t   state_q, state_d;
  wb_dst_decode u_dec (.icode(icode), .ra(rA), .rb(rB), .cnd(cnd), .dst_e(dst_e), .dst_m(dst_m));
  always_comb begin
    commit  = state_q == RUN && wb_valid && stat == STAT_AOK;
    state_d = (state_q == RUN && wb_valid && stat != STAT_AOK) ? HALTED : state_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  // valM is written second so it wins when both destinations name the same register
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      regs[REG_RSP] <= RSP_INIT;
    end else if (commit) begin
      if (dst_e != REG_NONE) regs[dst_e] <= valE;
      if (dst_m != REG_NONE) regs[dst_m] <= valM;
    end
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n) retired_cnt <= '0;
    else if (commit) retired_cnt <= retired_cnt + 64'd1;
`endif
  assign halted     = state_q == HALTED;
  assign dstE_o     = dst_e;
  assign dstM_o     = dst_m;
  assign reg_file0  = regs[0];
  assign reg_file1  = regs[1];
  assign reg_file2  = regs[2];
  assign reg_file3  = regs[3];
  assign reg_file4  = regs[4];
  assign reg_file5  = regs[5];
  assign reg_file6  = regs[6];
  assign reg_file7  = regs[7];
  assign reg_file8  = regs[8];
  assign reg_file9  = regs[9];
  assign reg_file10 = regs[10];
  assign reg_file11 = regs[11];
  assign reg_file12 = regs[12];
  assign reg_file13 = regs[13];
  assign reg_file14 = regs[14];
endmodule

// File: doc/writeback_regfile_seq.md
Name: writeback_regfile_seq

Overview:
- Write-back end of the sequential Y86-64 register path: owns the 15-entry, 64-bit architectural register file.
- Derives dstE/dstM from icode, rA, rB and cnd; commits valE/valM on the clock edge.
- Drives reg_file0..reg_file14 to the decode stage, which reads them.
- Tracks machine status: after any non-AOK stat it freezes the register file until reset.

Parameters:
- RSP_INIT, 64'h0000_0000_0000_0200, reset value of register 4 (%rsp).
- NREG, 15, number of architectural registers (IDs 0..14; ID 4'hF means "none").

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wb_valid  input  1  high for one cycle when the current instruction's results are ready to commit.
- icode  input  4  instruction code of the committing instruction.
- rA  input  4  register A field.
- rB  input  4  register B field.
- cnd  input  1  condition flag from execute; used by cmovXX.
- valE  input  64  ALU result.
- valM  input  64  memory read data.
- stat  input  2  instruction status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- reg_file0..reg_file14  output  64 each  registered architectural register contents.
- halted  output  1  sticky; high once a non-AOK stat has been committed.
- dstE_o  output  4  combinational dstE, for debug and trace.
- dstM_o  output  4  combinational dstM, for debug and trace.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All registers go to 0, except reg_file4, which goes to RSP_INIT.
  - halted goes to 0; FSM goes to RUN.
  - Reset overrides any write or halt in the same cycle.
- dstE decode (combinational):
  - 2 cmovXX: cnd ? rB : F.
  - 3 irmovq, 6 OPq: rB.
  - 8 call, 9 ret, A pushq, B popq: 4.
  - All other icodes: F.
- dstM decode (combinational):
  - 5 mrmovq, B popq: rA.
  - All other icodes: F.
- FSM states:
  - RUN: on wb_valid with stat == AOK, commit writes.
  - RUN: on wb_valid with stat != AOK, no writes that cycle; go to HALTED and set halted = 1.
  - HALTED: ignore all inputs; reg_file outputs are frozen. Only rst_n exits this state.
- Write rules, when a commit occurs:
  - reg[dstE] <= valE if dstE != F.
  - reg[dstM] <= valM if dstM != F.
  - If dstE == dstM != F, valM wins (popq %rsp semantics).
- Latency:
  - Written values appear on reg_file outputs one cycle after the commit edge.
  - No internal bypass; decode sees the pre-write value during the commit cycle.
- Other conditions:
  - Register IDs 0..14 are all writable; ID F is never written; there is no storage for ID 15.
  - wb_valid low: no state change.
  - icode values C..F with stat AOK: treated as no-write; no halt, since stat is authoritative.
  - Reset asserted while HALTED: full re-init and return to RUN.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined, add output retired_cnt [63:0]:
  - Reset value 0.
  - Increments by 1 on each commit in RUN with stat == AOK.
  - Frozen in HALTED; wraps at 2^64-1 → 0.
- When undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - REG_RSP = 4, REG_NONE = 4'hF.
  - stat encodings STAT_AOK/HLT/ADR/INS.
  - FSM state typedef {RUN, HALTED}.
- One natural sub-module: wb_dst_decode (combinational icode/rA/rB/cnd → dstE, dstM). Reusable by the pipelined version.

Test Plan:
- Reset: hold rst_n low for 2 cycles → all reg_file = 0, reg_file4 = 64'h200, halted = 0.
- irmovq: icode 3, rB = 2, valE = 64'hDEAD_BEEF, wb_valid → next cycle reg_file2 = 64'hDEAD_BEEF; no other register changes.
- cmov: icode 2, rB = 5, valE = 7:
  - cnd = 0 → reg_file5 unchanged.
  - Repeat with cnd = 1 → reg_file5 = 7.
- popq: icode B, rA = 3, valE = 64'h208, valM = 64'h55 → reg_file4 = 64'h208, reg_file3 = 64'h55.
- popq %rsp conflict: rA = 4, valE = 64'h210, valM = 64'h99 → reg_file4 = 64'h99.
- Halt: icode 6, rB = 1, stat = HLT → reg_file1 unchanged, halted = 1. Then irmovq to r1 with stat AOK → ignored. Then rst_n low → full re-init, halted = 0; with WB_RETIRE_CNT_EN, retired_cnt = 0.
